// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: arbitrates PC+4, ID jump and EX branch targets, buffers redirects while fetch is blocked.
// Optional redirect statistics counters are enabled by defining REDIRECT_STATS_EN.
module pc_redirect_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int STALL_LIMIT = 15
) (
  input  logic              ClockIn,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PC_Current,
  input  logic              IF_Ready,
  input  logic              ID_JumpFlag,
  input  logic [ADDR_W-1:0] ID_JumpAddress,
  input  logic              EX_BranchTaken,
  input  logic [ADDR_W-1:0] EX_BranchAddress,
  input  logic              ID_Stall,
  output logic [ADDR_W-1:0] PC_Next,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Flush,
  output logic              Redirect_Pending,
  output logic              Stall_Timeout
`ifdef REDIRECT_STATS_EN
  ,
  output logic [15:0]       Jump_Count,
  output logic [15:0]       Branch_Count
`endif
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_tgt_q;
  logic [7:0]        blk_cnt_q;
  logic              latch_en;
  logic [ADDR_W-1:0] latch_tgt;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign seq_pc  = align_word(PC_Current + ADDR_W'(4));
  assign br_tgt  = align_word(EX_BranchAddress);
  assign jmp_tgt = align_word(ID_JumpAddress);

  // State register
  always_ff @(posedge ClockIn) begin
    if (Reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if ((EX_BranchTaken || ID_JumpFlag) && !IF_Ready) state_d = PEND;
      PEND:    if (IF_Ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Pending target capture; a newer branch in PEND overwrites an older buffered jump target.
  always_comb begin
    latch_en  = 1'b0;
    latch_tgt = br_tgt;
    if (!IF_Ready) begin
      if (EX_BranchTaken) begin
        latch_en  = 1'b1;
        latch_tgt = br_tgt;
      end else if (ID_JumpFlag && state_q == RUN) begin
        latch_en  = 1'b1;
        latch_tgt = jmp_tgt;
      end
    end
  end

  always_ff @(posedge ClockIn) begin
    if (latch_en) pend_tgt_q <= latch_tgt;
  end

  // Output logic
  always_comb begin
    PC_Next    = seq_pc;
    PC_Write   = 1'b0;
    IFID_Write = 1'b0;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    if (Reset) begin
      PC_Next    = '0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (EX_BranchTaken) begin
            PC_Next    = br_tgt;
            PC_Write   = IF_Ready;
            IFID_Write = IF_Ready;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (ID_JumpFlag) begin
            PC_Next    = jmp_tgt;
            PC_Write   = IF_Ready;
            IFID_Write = IF_Ready;
            IFID_Flush = 1'b1;
          end else if (ID_Stall) begin
            PC_Next    = align_word(PC_Current);
            IDEX_Flush = 1'b1;
          end else begin
            PC_Write   = IF_Ready;
            IFID_Write = IF_Ready;
          end
        end
        PEND: begin
          PC_Next    = EX_BranchTaken ? br_tgt : pend_tgt_q;
          PC_Write   = IF_Ready;
          IFID_Write = IF_Ready;
          IFID_Flush = 1'b1;
          IDEX_Flush = EX_BranchTaken;
        end
        default: ;
      endcase
    end
  end

  assign Redirect_Pending = (state_q == PEND);
  assign Stall_Timeout    = (blk_cnt_q >= LIMIT);

  // Blocked-cycle counter
  always_ff @(posedge ClockIn) begin
    if (Reset)         blk_cnt_q <= 8'd0;
    else if (PC_Write) blk_cnt_q <= 8'd0;
    else               blk_cnt_q <= sat_inc(blk_cnt_q);
  end

`ifdef REDIRECT_STATS_EN
  logic pend_is_br_q;
  logic apply_redirect;
  logic apply_br;

  always_ff @(posedge ClockIn) begin
    if (latch_en) pend_is_br_q <= EX_BranchTaken;
  end

  assign apply_redirect = PC_Write && (state_q == PEND || EX_BranchTaken || ID_JumpFlag);
  assign apply_br       = PC_Write && (EX_BranchTaken || (state_q == PEND && pend_is_br_q));

  // Redirect statistics
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      Jump_Count   <= 16'd0;
      Branch_Count <= 16'd0;
    end else begin
      if (apply_br)                      Branch_Count <= Branch_Count + 16'd1;
      else if (apply_redirect)           Jump_Count   <= Jump_Count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] M = 32'hFFFF_FFFC;

  logic        ClockIn = 1'b0;
  logic        Reset;
  logic [31:0] PC_Current;
  logic        IF_Ready;
  logic        ID_JumpFlag;
  logic [31:0] ID_JumpAddress;
  logic        EX_BranchTaken;
  logic [31:0] EX_BranchAddress;
  logic        ID_Stall;
  logic [31:0] PC_Next;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Redirect_Pending, Stall_Timeout;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state
  bit          mdl_pend;
  logic [31:0] mdl_tgt;
  int          mdl_cnt;

  typedef struct {
    logic [31:0] nxt;
    logic pcw, ifw, ff, xf;
    bit   nxt_care, ifw_care, xf_care;
  } exp_t;

  pc_redirect_ctrl #(.ADDR_W(32), .STALL_LIMIT(15)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .PC_Current(PC_Current), .IF_Ready(IF_Ready),
    .ID_JumpFlag(ID_JumpFlag), .ID_JumpAddress(ID_JumpAddress),
    .EX_BranchTaken(EX_BranchTaken), .EX_BranchAddress(EX_BranchAddress),
    .ID_Stall(ID_Stall), .PC_Next(PC_Next), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .Redirect_Pending(Redirect_Pending),
    .Stall_Timeout(Stall_Timeout)
  );

  always #5 ClockIn = ~ClockIn;

  function automatic exp_t model_out();
    exp_t e;
    e = '{nxt: 32'h0, pcw: 1'b0, ifw: 1'b0, ff: 1'b0, xf: 1'b0,
          nxt_care: 1'b1, ifw_care: 1'b0, xf_care: 1'b1};
    if (Reset) begin
      e.ff = 1'b1; e.xf = 1'b1; e.ifw_care = 1'b1;
    end else if (mdl_pend) begin
      e.ff = 1'b1; e.pcw = IF_Ready;
      e.xf = EX_BranchTaken; e.xf_care = EX_BranchTaken;
      e.nxt = EX_BranchTaken ? (EX_BranchAddress & M) : mdl_tgt;
      e.nxt_care = IF_Ready;
    end else if (EX_BranchTaken) begin
      e.ff = 1'b1; e.xf = 1'b1; e.pcw = IF_Ready;
      e.nxt = EX_BranchAddress & M; e.nxt_care = IF_Ready;
    end else if (ID_JumpFlag) begin
      e.ff = 1'b1; e.pcw = IF_Ready;
      e.nxt = ID_JumpAddress & M; e.nxt_care = IF_Ready;
    end else if (ID_Stall) begin
      e.xf = 1'b1; e.ifw_care = 1'b1; e.nxt_care = 1'b0;
    end else begin
      e.pcw = IF_Ready; e.ifw = IF_Ready; e.ifw_care = 1'b1;
      e.nxt = (PC_Current + 32'd4) & M;
    end
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    e = model_out();
    if (Reset) begin
      mdl_pend = 1'b0;
      mdl_cnt  = 0;
    end else begin
      if (e.pcw) mdl_cnt = 0;
      else if (mdl_cnt < 255) mdl_cnt++;
      if (mdl_pend) begin
        if (IF_Ready) mdl_pend = 1'b0;
        else if (EX_BranchTaken) mdl_tgt = EX_BranchAddress & M;
      end else if ((EX_BranchTaken || ID_JumpFlag) && !IF_Ready) begin
        mdl_pend = 1'b1;
        mdl_tgt  = EX_BranchTaken ? (EX_BranchAddress & M) : (ID_JumpAddress & M);
      end
    end
    @(posedge ClockIn);
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 1'b0; IF_Ready = 1'b1; ID_JumpFlag = 1'b0; EX_BranchTaken = 1'b0; ID_Stall = 1'b0;
    ID_JumpAddress = 32'h0; EX_BranchAddress = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    PC_Current = 32'h0;
    Reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_cmp++; if (PC_Next !== 32'h0) begin n_err++; $display("FAIL reset_pc_next: got %h want %h", PC_Next, 32'h0); end
      n_cmp++; if ({PC_Write, IFID_Write} !== 2'b00) begin n_err++; $display("FAIL reset_writes: got %b want 00", {PC_Write, IFID_Write}); end
      n_cmp++; if ({IFID_Flush, IDEX_Flush} !== 2'b11) begin n_err++; $display("FAIL reset_flushes: got %b want 11", {IFID_Flush, IDEX_Flush}); end
      if (c == 1) begin
        n_cmp++; if ({Redirect_Pending, Stall_Timeout} !== 2'b00) begin n_err++; $display("FAIL reset_status: got %b want 00", {Redirect_Pending, Stall_Timeout}); end
      end
      tick();
    end
  endtask

  task automatic test_sequential();
    idle_inputs();
    PC_Current = 32'h0;
    #2;
    n_cmp++; if (PC_Next !== 32'h4) begin n_err++; $display("FAIL seq_pc_next: got %h want %h", PC_Next, 32'h4); end
    n_cmp++; if ({PC_Write, IFID_Write} !== 2'b11) begin n_err++; $display("FAIL seq_writes: got %b want 11", {PC_Write, IFID_Write}); end
    n_cmp++; if ({IFID_Flush, IDEX_Flush} !== 2'b00) begin n_err++; $display("FAIL seq_flushes: got %b want 00", {IFID_Flush, IDEX_Flush}); end
    tick();
  endtask

  task automatic test_jump();
    idle_inputs();
    PC_Current = 32'h4; ID_JumpFlag = 1'b1; ID_JumpAddress = 32'h40; ID_Stall = 1'b1;
    #2;
    n_cmp++; if (PC_Next !== 32'h40) begin n_err++; $display("FAIL jump_pc_next: got %h want %h", PC_Next, 32'h40); end
    n_cmp++; if (PC_Write !== 1'b1) begin n_err++; $display("FAIL jump_pc_write: got %b want 1", PC_Write); end
    n_cmp++; if ({IFID_Flush, IDEX_Flush} !== 2'b10) begin n_err++; $display("FAIL jump_flushes: got %b want 10", {IFID_Flush, IDEX_Flush}); end
    tick();
  endtask

  task automatic test_branch_over_jump();
    idle_inputs();
    PC_Current = 32'h40; ID_JumpFlag = 1'b1; ID_JumpAddress = 32'h40;
    EX_BranchTaken = 1'b1; EX_BranchAddress = 32'h83;
    #2;
    n_cmp++; if (PC_Next !== 32'h80) begin n_err++; $display("FAIL branch_pc_next: got %h want %h", PC_Next, 32'h80); end
    n_cmp++; if (PC_Write !== 1'b1) begin n_err++; $display("FAIL branch_pc_write: got %b want 1", PC_Write); end
    n_cmp++; if ({IFID_Flush, IDEX_Flush} !== 2'b11) begin n_err++; $display("FAIL branch_flushes: got %b want 11", {IFID_Flush, IDEX_Flush}); end
    tick();
  endtask

  task automatic test_pending();
    idle_inputs();
    PC_Current = 32'h80; IF_Ready = 1'b0; ID_JumpFlag = 1'b1; ID_JumpAddress = 32'h40;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++; if (PC_Write !== 1'b0) begin n_err++; $display("FAIL pend_pc_write c%0d: got %b want 0", c, PC_Write); end
      n_cmp++; if (Redirect_Pending !== (c != 0)) begin n_err++; $display("FAIL pend_flag c%0d: got %b want %b", c, Redirect_Pending, c != 0); end
      n_cmp++; if (IFID_Flush !== 1'b1) begin n_err++; $display("FAIL pend_ifid_flush c%0d: got %b want 1", c, IFID_Flush); end
      tick();
      ID_JumpFlag = (c == 0) ? 1'b0 : 1'b1;
      ID_JumpAddress = 32'h200;
    end
    ID_JumpFlag = 1'b0; IF_Ready = 1'b1;
    #2;
    n_cmp++; if (PC_Next !== 32'h40) begin n_err++; $display("FAIL pend_apply_pc: got %h want %h", PC_Next, 32'h40); end
    n_cmp++; if (PC_Write !== 1'b1) begin n_err++; $display("FAIL pend_apply_write: got %b want 1", PC_Write); end
    tick();
    PC_Current = 32'h40;
    #2;
    n_cmp++; if (Redirect_Pending !== 1'b0) begin n_err++; $display("FAIL pend_cleared: got %b want 0", Redirect_Pending); end
    n_cmp++; if (PC_Next !== 32'h44) begin n_err++; $display("FAIL pend_after_pc: got %h want %h", PC_Next, 32'h44); end
    tick();
  endtask

  task automatic test_pending_overwrite();
    idle_inputs();
    PC_Current = 32'h44; IF_Ready = 1'b0; ID_JumpFlag = 1'b1; ID_JumpAddress = 32'h100;
    tick();
    ID_JumpFlag = 1'b0; EX_BranchTaken = 1'b1; EX_BranchAddress = 32'h300;
    #2;
    n_cmp++; if ({IFID_Flush, IDEX_Flush} !== 2'b11) begin n_err++; $display("FAIL ovw_flushes: got %b want 11", {IFID_Flush, IDEX_Flush}); end
    tick();
    EX_BranchTaken = 1'b0; IF_Ready = 1'b1;
    #2;
    n_cmp++; if (PC_Next !== 32'h300) begin n_err++; $display("FAIL ovw_pc_next: got %h want %h", PC_Next, 32'h300); end
    n_cmp++; if (PC_Write !== 1'b1) begin n_err++; $display("FAIL ovw_pc_write: got %b want 1", PC_Write); end
    tick();
  endtask

  task automatic test_stall_timeout();
    idle_inputs();
    PC_Current = 32'h300; ID_Stall = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      #2;
      n_cmp++; if ({PC_Write, IFID_Write, IDEX_Flush} !== 3'b001) begin n_err++; $display("FAIL stall_ctrl k%0d: got %b want 001", k, {PC_Write, IFID_Write, IDEX_Flush}); end
      n_cmp++; if (Stall_Timeout !== (k >= 16)) begin n_err++; $display("FAIL stall_timeout k%0d: got %b want %b", k, Stall_Timeout, k >= 16); end
      tick();
    end
    ID_Stall = 1'b0;
    #2;
    n_cmp++; if (PC_Write !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b want 1", PC_Write); end
    tick();
    #2;
    n_cmp++; if (Stall_Timeout !== 1'b0) begin n_err++; $display("FAIL stall_timeout_clear: got %b want 0", Stall_Timeout); end
  endtask

  task automatic test_saturation();
    idle_inputs();
    IF_Ready = 1'b0;
    for (int k = 1; k <= 270; k++) begin
      #2;
      if (k >= 250) begin
        n_cmp++; if (Stall_Timeout !== 1'b1) begin n_err++; $display("FAIL sat_timeout k%0d: got %b want 1", k, Stall_Timeout); end
      end
      tick();
    end
  endtask

  task automatic test_wrap_and_reset_in_pend();
    idle_inputs();
    PC_Current = 32'hFFFF_FFFC;
    #2;
    n_cmp++; if (PC_Next !== 32'h0) begin n_err++; $display("FAIL wrap_pc_next: got %h want %h", PC_Next, 32'h0); end
    tick();
    PC_Current = 32'h0; IF_Ready = 1'b0; ID_JumpFlag = 1'b1; ID_JumpAddress = 32'h40;
    tick();
    ID_JumpFlag = 1'b0; Reset = 1'b1; IF_Ready = 1'b1;
    #2;
    n_cmp++; if ({PC_Write, PC_Next} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL rstpend_outputs: got %b/%h want 0/0", PC_Write, PC_Next); end
    tick();
    Reset = 1'b0;
    #2;
    n_cmp++; if (Redirect_Pending !== 1'b0) begin n_err++; $display("FAIL rstpend_cleared: got %b want 0", Redirect_Pending); end
    n_cmp++; if (PC_Next !== 32'h4) begin n_err++; $display("FAIL rstpend_pc_next: got %h want %h", PC_Next, 32'h4); end
    tick();
  endtask

  task automatic test_random();
    exp_t e;
    for (int c = 0; c < 600; c++) begin
      Reset            = ($urandom_range(0, 49) == 0);
      IF_Ready         = ($urandom_range(0, 9) < 6);
      EX_BranchTaken   = ($urandom_range(0, 7) == 0);
      ID_JumpFlag      = ($urandom_range(0, 4) == 0);
      ID_Stall         = ($urandom_range(0, 4) == 0);
      EX_BranchAddress = $urandom;
      ID_JumpAddress   = $urandom;
      PC_Current       = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      #2;
      e = model_out();
      n_cmp++; if (PC_Write !== e.pcw) begin n_err++; $display("FAIL rnd_pc_write c%0d: got %b want %b", c, PC_Write, e.pcw); end
      if (e.nxt_care) begin
        n_cmp++; if (PC_Next !== e.nxt) begin n_err++; $display("FAIL rnd_pc_next c%0d: got %h want %h", c, PC_Next, e.nxt); end
      end
      if (e.ifw_care) begin
        n_cmp++; if (IFID_Write !== e.ifw) begin n_err++; $display("FAIL rnd_ifid_write c%0d: got %b want %b", c, IFID_Write, e.ifw); end
      end
      n_cmp++; if (IFID_Flush !== e.ff) begin n_err++; $display("FAIL rnd_ifid_flush c%0d: got %b want %b", c, IFID_Flush, e.ff); end
      if (e.xf_care) begin
        n_cmp++; if (IDEX_Flush !== e.xf) begin n_err++; $display("FAIL rnd_idex_flush c%0d: got %b want %b", c, IDEX_Flush, e.xf); end
      end
      n_cmp++; if (Redirect_Pending !== mdl_pend) begin n_err++; $display("FAIL rnd_pending c%0d: got %b want %b", c, Redirect_Pending, mdl_pend); end
      n_cmp++; if (Stall_Timeout !== (mdl_cnt >= 15)) begin n_err++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, Stall_Timeout, mdl_cnt >= 15); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch_over_jump();
    test_pending();
    test_pending_overwrite();
    test_stall_timeout();
    test_saturation();
    test_wrap_and_reset_in_pend();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
